// File: rtl/ucc8_pkg.sv
// Shared width and mode encoding for the ucc8_always cascadable counter cell.
package ucc8_pkg;

    localparam int WIDTH = 8;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_CLR  = 2'b11
    } ucc8_mode_e;

endpackage

// File: rtl/ucc8_always.sv
// 8-bit cascadable up/down/hold/clear counter cell with carry and mode ripple.
// Define UCC8_ALWAYS_MOUT_REG_EN to register mout (downstream sees mode one cycle late).
module ucc8_always
    import ucc8_pkg::*;
(
    output logic [WIDTH-1:0] fout,
    output logic             cout,
    output logic [1:0]       mout,
    input  logic             cin,
    input  logic             rst,
    input  logic             clk,
    input  logic [1:0]       min
);

    ucc8_mode_e mode;
    assign mode = ucc8_mode_e'(min);

    always_ff @(posedge clk) begin
        if (rst) begin
            fout <= '0;
`ifdef UCC8_ALWAYS_MOUT_REG_EN
            mout <= 2'b00;
`endif
        end else begin
            case (mode)
                MODE_UP:   if (cin) fout <= fout + WIDTH'(1);
                MODE_DOWN: if (cin) fout <= fout - WIDTH'(1);
                MODE_CLR:  fout <= '0;
                default:   fout <= fout;
            endcase
`ifdef UCC8_ALWAYS_MOUT_REG_EN
            mout <= min;
`endif
        end
    end

`ifndef UCC8_ALWAYS_MOUT_REG_EN
    assign mout = min;
`endif

    // Terminal-count detect lets the next cell advance on the same edge that wraps this one.
    always_comb begin
        cout = 1'b0;
        case (mode)
            MODE_UP:   cout = cin & (fout == {WIDTH{1'b1}});
            MODE_DOWN: cout = cin & (fout == '0);
            default:   cout = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_ucc8_always.sv
// Self-checking bench for ucc8_always: vector table plus wrap sequences, scoreboard queue.
module tb_ucc8_always;

    logic       clk;
    logic       rst;
    logic [1:0] min;
    logic       cin;
    logic [7:0] fout;
    logic       cout;
    logic [1:0] mout;

    int checks = 0;
    int errors = 0;

    logic [8:0] exp_q[$];
    logic [1:0] mout_q;

    typedef struct {
        logic       r;
        logic [1:0] m;
        logic       c;
        logic [7:0] ef;
        logic       ec;
        string      name;
    } vec_t;

    vec_t vecs[$];

    ucc8_always dut (
        .fout (fout),
        .cout (cout),
        .mout (mout),
        .cin  (cin),
        .rst  (rst),
        .clk  (clk),
        .min  (min)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        rst    = 1'b1;
        min    = 2'b00;
        cin    = 1'b0;
        mout_q = 2'b00;
    end

    // One cycle: drive at negedge, check mout pre-edge, check fout/cout after the edge.
    task automatic step(input logic r, input logic [1:0] m, input logic c,
                        input logic [7:0] ef, input logic ec, input string name);
        logic [1:0] em;
        logic [8:0] exp_v;
        logic [8:0] got_v;
        @(negedge clk);
        rst = r;
        min = m;
        cin = c;
        exp_q.push_back({ef, ec});
`ifdef UCC8_ALWAYS_MOUT_REG_EN
        em = mout_q;
`else
        em = m;
`endif
        #1;
        checks++;
        if (mout !== em) begin
            errors++;
            $display("FAIL %s mout got %b exp %b", name, mout, em);
        end
        @(posedge clk);
        mout_q = r ? 2'b00 : m;
        #1;
        exp_v = exp_q.pop_front();
        got_v = {fout, cout};
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s fout/cout got %h/%b exp %h/%b",
                     name, got_v[8:1], got_v[0], exp_v[8:1], exp_v[0]);
        end
    endtask

    initial begin
        //           rst  min    cin   fout   cout  name
        vecs.push_back('{1'b1, 2'b00, 1'b0, 8'h00, 1'b0, "reset0"});
        vecs.push_back('{1'b1, 2'b00, 1'b0, 8'h00, 1'b0, "reset1"});
        vecs.push_back('{1'b1, 2'b00, 1'b0, 8'h00, 1'b0, "reset2"});
        vecs.push_back('{1'b0, 2'b11, 1'b1, 8'h00, 1'b0, "clear"});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 8'h00, 1'b0, "up_noen0"});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 8'h00, 1'b0, "up_noen1"});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 8'h00, 1'b0, "up_noen2"});
        vecs.push_back('{1'b0, 2'b01, 1'b1, 8'h01, 1'b0, "up1"});
        vecs.push_back('{1'b0, 2'b01, 1'b1, 8'h02, 1'b0, "up2"});
        vecs.push_back('{1'b0, 2'b01, 1'b1, 8'h03, 1'b0, "up3"});
        vecs.push_back('{1'b0, 2'b01, 1'b1, 8'h04, 1'b0, "up4"});
        vecs.push_back('{1'b0, 2'b01, 1'b1, 8'h05, 1'b0, "up5"});
        vecs.push_back('{1'b0, 2'b00, 1'b1, 8'h05, 1'b0, "hold"});
        vecs.push_back('{1'b0, 2'b10, 1'b1, 8'h04, 1'b0, "dn4"});
        vecs.push_back('{1'b0, 2'b10, 1'b1, 8'h03, 1'b0, "dn3"});
        vecs.push_back('{1'b0, 2'b10, 1'b1, 8'h02, 1'b0, "dn2"});
        vecs.push_back('{1'b0, 2'b10, 1'b1, 8'h01, 1'b0, "dn1"});
        vecs.push_back('{1'b0, 2'b10, 1'b1, 8'h00, 1'b1, "dn0"});
        vecs.push_back('{1'b0, 2'b10, 1'b1, 8'hff, 1'b0, "dn_wrap"});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 8'hff, 1'b0, "dn_noen"});
        vecs.push_back('{1'b0, 2'b00, 1'b0, 8'hff, 1'b0, "sweep00"});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 8'hff, 1'b0, "sweep01"});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 8'hff, 1'b0, "sweep10"});
        vecs.push_back('{1'b0, 2'b11, 1'b0, 8'h00, 1'b0, "sweep11"});
        vecs.push_back('{1'b0, 2'b10, 1'b1, 8'hff, 1'b0, "dn_from0"});
        vecs.push_back('{1'b1, 2'b10, 1'b1, 8'h00, 1'b1, "rst_dn_cout"});
        vecs.push_back('{1'b0, 2'b01, 1'b1, 8'h01, 1'b0, "after_rst"});
        vecs.push_back('{1'b1, 2'b01, 1'b1, 8'h00, 1'b0, "rst_over_up"});

        foreach (vecs[i])
            step(vecs[i].r, vecs[i].m, vecs[i].c, vecs[i].ef, vecs[i].ec, vecs[i].name);

        // Up-wrap corner: climb from 00 to FD, then FE, FF with cout, then wrap to 00.
        step(1'b0, 2'b11, 1'b0, 8'h00, 1'b0, "wrap_clr");
        for (int i = 1; i <= 253; i++)
            step(1'b0, 2'b01, 1'b1, 8'(i), 1'b0, "climb");
        step(1'b0, 2'b01, 1'b1, 8'hfe, 1'b0, "up_fe");
        step(1'b0, 2'b01, 1'b1, 8'hff, 1'b1, "up_ff");
        step(1'b0, 2'b01, 1'b1, 8'h00, 1'b0, "up_wrap");

        // Terminal value with enable dropped must not assert cout.
        step(1'b0, 2'b10, 1'b1, 8'hff, 1'b0, "dn_to_ff");
        step(1'b0, 2'b01, 1'b0, 8'hff, 1'b0, "ff_noen");
        step(1'b0, 2'b01, 1'b1, 8'h00, 1'b0, "ff_wrap2");

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got %0d exp 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
